bcd_to_hex: RTL and testbench

BCD_TO_HEX -- requirements
Module: bcd_to_hex

---
 rtl/bcd_to_hex.sv | 113 +++++++++++
 tb/tb_bcd_to_hex.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_hex.sv
// ============================================================================
// Module   : bcd_to_hex
// Brief    : Sequential 4-digit packed-BCD to binary converter (reverse double-dabble)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_hex #(
    parameter logic [1:0] IDLE     = 2'b00,
    parameter logic [1:0] SHIFTING = 2'b01,
    parameter logic [1:0] DONE     = 2'b10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INP_VALID,
    input  logic [15:0] INP_DEC_DATA,
    output logic [15:0] OUT_HEX_DATA,
    output logic        OUT_VALID,
    output logic        OUT_ERR,
    output logic        BUSY
);

    localparam logic [4:0] c_NUM_SHIFTS = 5'd16;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_work;
    logic        r_err;
    logic [15:0] r_out_hex;
    logic        r_out_valid;
    logic        r_out_err;

    logic [31:0] w_shift;
    logic [31:0] w_next;
    logic [3:0]  w_digit_bad;
    logic        w_in_err;

    assign w_shift       = {1'b0, r_work[31:1]};
    assign w_next[15:0]  = w_shift[15:0];

    // Each BCD nibble that received a carried-in 8 is corrected back by 3 (mod 16).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            logic [3:0] w_nib;
            assign w_nib = w_shift[16 + 4*gi +: 4];
            assign w_next[16 + 4*gi +: 4] = (w_nib >= 4'h8) ? (w_nib - 4'h3) : w_nib;
            assign w_digit_bad[gi] = (INP_DEC_DATA[4*gi +: 4] > 4'h9);
        end
    endgenerate

    assign w_in_err = |w_digit_bad;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_count     <= 5'd0;
            r_work      <= 32'h0;
            r_err       <= 1'b0;
            r_out_hex   <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (INP_VALID) begin
                        r_work  <= {INP_DEC_DATA, 16'h0000};
                        r_count <= c_NUM_SHIFTS;
                        r_err   <= w_in_err;
                        r_state <= SHIFTING;
                    end
                end
                SHIFTING: begin
                    if (INP_VALID) begin
                        r_work  <= {INP_DEC_DATA, 16'h0000};
                        r_count <= c_NUM_SHIFTS;
                        r_err   <= w_in_err;
                    end else begin
                        r_work  <= w_next;
                        r_count <= r_count - 5'd1;
                        if (r_count == 5'd1) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_out_hex   <= r_err ? 16'h0000 : r_work[15:0];
                    r_out_err   <= r_err;
                    r_out_valid <= 1'b1;
                    if (INP_VALID) begin
                        r_work  <= {INP_DEC_DATA, 16'h0000};
                        r_count <= c_NUM_SHIFTS;
                        r_err   <= w_in_err;
                        r_state <= SHIFTING;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign OUT_HEX_DATA = r_out_hex;
    assign OUT_VALID    = r_out_valid;
    assign OUT_ERR      = r_out_err;
    assign BUSY         = (r_state == SHIFTING) || (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_hex.sv
// ============================================================================
// Module   : tb_bcd_to_hex
// Brief    : Self-checking bench for bcd_to_hex against a decimal-arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_hex;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INP_VALID;
    logic [15:0] INP_DEC_DATA;
    logic [15:0] OUT_HEX_DATA;
    logic        OUT_VALID;
    logic        OUT_ERR;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a capture schedules a publish 17 edges later; m_left counts down to it.
    int          m_left;
    logic [15:0] m_pend_val;
    logic        m_pend_err;
    logic [15:0] m_hex;
    logic        m_err;
    logic        m_valid;

    bcd_to_hex dut (
        .CLK          (CLK),
        .RST          (RST),
        .INP_VALID    (INP_VALID),
        .INP_DEC_DATA (INP_DEC_DATA),
        .OUT_HEX_DATA (OUT_HEX_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_ERR      (OUT_ERR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_left  = 0;
        m_hex   = 16'h0000;
        m_err   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [15:0] d);
        int dig [4];
        int val;
        logic bad;
        m_valid = 1'b0;
        if (m_left == 1) begin
            m_hex   = m_pend_err ? 16'h0000 : m_pend_val;
            m_err   = m_pend_err;
            m_valid = 1'b1;
        end
        if (v) begin
            bad = 1'b0;
            val = 0;
            for (int k = 3; k >= 0; k--) begin
                dig[k] = int'(d[4*k +: 4]);
                if (dig[k] > 9) bad = 1'b1;
                val = val * 10 + dig[k];
            end
            m_pend_val = 16'(val);
            m_pend_err = bad;
            m_left     = 17;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("hex",   OUT_HEX_DATA,        m_hex);
        check("err",   {15'h0, OUT_ERR},    {15'h0, m_err});
        check("valid", {15'h0, OUT_VALID},  {15'h0, m_valid});
        check("busy",  {15'h0, BUSY},       {15'h0, (m_left > 0)});
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        INP_VALID    = v;
        INP_DEC_DATA = d;
        @(posedge CLK);
        if (RST) model_edge(v, d);
        else     model_reset();
        #1;
        compare();
        INP_VALID    = 1'b0;
        INP_DEC_DATA = 16'h0000;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0000);
    endtask

    task automatic wait_valid(input int limit, output int edges);
        edges = 0;
        do begin
            step(1'b0, 16'h0000);
            edges++;
        end while (!OUT_VALID && edges < limit);
        n_cmp++;
        if (!OUT_VALID) begin
            n_bad++;
            $display("FAIL wait_valid: no OUT_VALID within %0d edges", limit);
        end
    endtask

    task automatic convert(input string name, input logic [15:0] d,
                           input logic [15:0] exp_hex, input logic exp_err);
        int e;
        step(1'b1, d);
        wait_valid(40, e);
        check({name, "_lat"}, 16'(e), 16'd17);
        check({name, "_hex"}, OUT_HEX_DATA, exp_hex);
        check({name, "_err"}, {15'h0, OUT_ERR}, {15'h0, exp_err});
        idle(1);
    endtask

    initial begin
        int e;
        int busy_cnt;
        logic [15:0] vec [6];
        vec = '{16'h0009, 16'h0010, 16'h9990, 16'hF000, 16'h0500, 16'h2025};

        RST          = 1'b0;
        INP_VALID    = 1'b0;
        INP_DEC_DATA = 16'h0000;
        model_reset();
        #1;
        compare();
        @(negedge CLK);
        RST = 1'b1;
        idle(2);

        // 9999: result, latency, and BUSY width
        step(1'b1, 16'h9999);
        busy_cnt = BUSY ? 1 : 0;
        e = 0;
        while (!OUT_VALID && e < 40) begin
            step(1'b0, 16'h0000);
            e++;
            if (BUSY) busy_cnt++;
        end
        check("9999_lat", 16'(e), 16'd17);
        check("9999_hex", OUT_HEX_DATA, 16'h270F);
        check("9999_err", {15'h0, OUT_ERR}, 16'h0);
        check("9999_busy", 16'(busy_cnt), 16'd17);
        idle(1);
        check("valid_one_cycle", {15'h0, OUT_VALID}, 16'h0);

        convert("1234", 16'h1234, 16'h04D2, 1'b0);
        convert("0000", 16'h0000, 16'h0000, 1'b0);
        convert("0001", 16'h0001, 16'h0001, 1'b0);
        convert("12A4", 16'h12A4, 16'h0000, 1'b1);
        convert("0042", 16'h0042, 16'h002A, 1'b0);

        // Restart after 8 shifts
        step(1'b1, 16'h5555);
        idle(8);
        convert("restart", 16'h0100, 16'h0064, 1'b0);

        // Async reset in the middle of shift 5
        step(1'b1, 16'h8888);
        idle(4);
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        compare();
        idle(2);
        RST = 1'b1;
        check("rst_hex", OUT_HEX_DATA, 16'h0000);
        idle(20);
        convert("8888", 16'h8888, 16'h22B8, 1'b0);

        // New input on the DONE edge
        step(1'b1, 16'h0099);
        idle(16);
        step(1'b1, 16'h0010);
        check("0099_valid", {15'h0, OUT_VALID}, 16'h1);
        check("0099_hex", OUT_HEX_DATA, 16'h0063);
        wait_valid(40, e);
        check("0010_lat", 16'(e), 16'd17);
        check("0010_hex", OUT_HEX_DATA, 16'h000A);
        idle(2);

        // Further vectors checked against the model only
        foreach (vec[k]) begin
            step(1'b1, vec[k]);
            wait_valid(40, e);
            idle(1 + k % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
